filt_capture: RTL and testbench
===============================

FILT_CAPTURE -- requirements
Module: filt_capture

Interface
REQ-001 Parameter WIDTH, default 8: sample width of filter output y.
REQ-002 Parameter DEPTH, default 16: capture FIFO entries; power of two, >= 2.
REQ-003 Parameter LEN_W, default 10: width of capture length field.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  capture request; sampled in IDLE or DONE only.
REQ-007 len  input  LEN_W  number of samples to capture; latched on accepted start.
REQ-008 y  input  WIDTH  filter output sample.
REQ-009 y_valid  input  1  y carries a new sample this cycle.
REQ-010 out_data  output  WIDTH  FIFO head sample.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  consumer accepts out_data.
REQ-013 busy  output  1  high in CAPTURE.
REQ-014 done  output  1  one-cycle pulse when capture completes.
REQ-015 overflow  output  1  sticky: a sample was dropped because the FIFO was full.
REQ-016 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 FSM states IDLE, CAPTURE, DONE; reset state IDLE.
REQ-018 IDLE/DONE with start=1 and len!=0: latch len into remaining, clear overflow, enter CAPTURE next cycle.
REQ-019 IDLE/DONE with start=1 and len=0: no samples written, done pulses next cycle, state becomes DONE.
REQ-020 start in CAPTURE is ignored; len changes after acceptance have no effect.
REQ-021 In CAPTURE, each cycle with y_valid=1 consumes one sample: remaining decrements by 1; sample written to FIFO tail if not full.
REQ-022 Sample arriving while FIFO full (after same-cycle pop accounted for) is dropped, still decrements remaining, sets overflow.
REQ-023 Simultaneous push and pop when full: pop frees the slot; push succeeds; no overflow.
REQ-024 y_valid outside CAPTURE is ignored; nothing written.
REQ-025 When remaining reaches 0 on a consumed sample, state becomes DONE next edge and done pulses high for exactly that one cycle.
REQ-026 FIFO read: out_valid = (level != 0); pop when out_valid and out_ready; out_data is the head entry, stable while out_valid=1 and out_ready=0.
REQ-027 Write-to-read latency: a sample written on edge N is visible on out_data with out_valid=1 after edge N (first-word fall-through, 1 cycle).
REQ-028 Draining continues in every state; FIFO contents persist into DONE and IDLE until read.
REQ-029 Read/write pointers wrap modulo DEPTH; level ranges 0..DEPTH inclusive.
REQ-030 Simultaneous push and pop when empty: push takes effect, no pop, level becomes 1.
REQ-031 A new start does not flush the FIFO; older samples drain first, in order.

Reset
REQ-032 rst_n=0 asynchronously forces: state IDLE, remaining 0, pointers 0, level 0, out_valid 0, busy 0, done 0, overflow 0, out_data 0.
REQ-033 Reset during CAPTURE aborts the capture; FIFO contents discarded; no done pulse.
REQ-034 First start is accepted on the first rising edge after rst_n deasserts.

Verification
REQ-035 len=5, y_valid=1 continuously, y=8'h10..8'h14, out_ready=1 -> out_data 10,11,12,13,14 in order; done pulses once, 1 cycle after 5th sample; overflow=0.
REQ-036 DEPTH=16, len=20, out_ready=0 -> level saturates at 16, overflow=1, done pulses after 20th y_valid; draining then yields the first 16 samples.
REQ-037 len=0 with start -> done pulses next cycle, level stays 0, busy never asserts.
REQ-038 FIFO full, push and pop in same cycle -> level stays 16, overflow stays 0, popped data = oldest entry.
REQ-039 rst_n low mid-capture (3 of 8 samples taken) -> all outputs at reset values immediately; no done; new start len=2 completes normally.
REQ-040 y_valid toggled 1-0-1-0 with len=3 -> exactly 3 samples captured; gap cycles do not decrement remaining.

Source files
------------

// File: rtl/filt_capture_if.sv
// filt_capture_if: capture request, filter sample input and FIFO read-side bundle.
interface filt_capture_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LEN_W = 10
);
  logic                     start;
  logic [LEN_W-1:0]         len;
  logic [WIDTH-1:0]         y;
  logic                     y_valid;
  logic [WIDTH-1:0]         out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;
  logic                     done;
  logic                     overflow;
  logic [$clog2(DEPTH):0]   level;
  modport master (
    output start, len, y, y_valid, out_ready,
    input  out_data, out_valid, busy, done, overflow, level
  );
  modport slave (
    input  start, len, y, y_valid, out_ready,
    output out_data, out_valid, busy, done, overflow, level
  );
endinterface

// File: rtl/filt_capture.sv
// filt_capture: captures a requested number of filter samples into a
// first-word fall-through FIFO, flagging drops when the FIFO is full.
module filt_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LEN_W = 10
) (
  input logic         clk,
  input logic         rst_n,
  filt_capture_if.slave io_cap
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  state_t             r_state, w_next;
  logic [LEN_W-1:0]   r_remaining;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [AW-1:0]      r_wptr, r_rptr;
  logic [LW-1:0]      r_level;
  logic               r_done, r_overflow;
  logic               w_accept, w_load, w_take, w_last, w_pop, w_push, w_full, w_busy;
  assign w_accept = (r_state != CAPTURE) && io_cap.start;
  assign w_load   = w_accept && (io_cap.len != '0);
  assign w_take   = (r_state == CAPTURE) && io_cap.y_valid;
  assign w_last   = w_take && (r_remaining == LEN_W'(1));
  assign w_pop    = (r_level != '0) && io_cap.out_ready;
  assign w_full   = r_level == LW'(DEPTH);
  // a pop in the same cycle frees the slot the push needs
  assign w_push   = w_take && (!w_full || w_pop);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (w_accept)    w_next = w_load ? CAPTURE : DONE;
    else if (w_last) w_next = DONE;
  end
  always_comb begin
    w_busy = r_state == CAPTURE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining <= '0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
    end else begin
      if (w_load)      r_remaining <= io_cap.len;
      else if (w_take) r_remaining <= r_remaining - LEN_W'(1);
      r_done <= (w_accept && !w_load) || w_last;
      if (w_load)                r_overflow <= 1'b0;
      else if (w_take && !w_push) r_overflow <= 1'b1;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= io_cap.y;
  end
  assign io_cap.out_valid = r_level != '0;
  assign io_cap.out_data  = (r_level != '0) ? r_mem[r_rptr] : '0;
  assign io_cap.busy      = w_busy;
  assign io_cap.done      = r_done;
  assign io_cap.overflow  = r_overflow;
  assign io_cap.level     = r_level;
endmodule

// File: tb/tb_filt_capture.sv
// tb_filt_capture: directed scenario tests for filt_capture with hand-computed expectations.
module tb_filt_capture;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] got [$];
  int dones;
  int done_cycle;
  int busy_seen;
  filt_capture_if #(.WIDTH(8), .DEPTH(16), .LEN_W(10)) cap ();
  filt_capture #(.WIDTH(8), .DEPTH(16), .LEN_W(10)) dut (.clk(clk), .rst_n(rst_n), .io_cap(cap));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // drives n cycles of samples base+c (every other cycle when gaps) and records pops and done pulses
  task automatic run_stream(input int n, input logic [7:0] base, input bit gaps);
    got.delete();
    dones = 0;
    done_cycle = -1;
    busy_seen = 0;
    for (int c = 0; c < n; c++) begin
      cap.y_valid = gaps ? ~c[0] : 1'b1;
      cap.y = base + 8'(c);
      step();
      if (cap.done) begin dones++; done_cycle = c; end
      if (cap.busy) busy_seen++;
      if (cap.out_valid && cap.out_ready) got.push_back(cap.out_data);
    end
    cap.y_valid = 1'b0;
  endtask
  task automatic test_reset();
    cap.start = 1'b0; cap.len = '0; cap.y = '0; cap.y_valid = 1'b0; cap.out_ready = 1'b0;
    rst_n = 1'b0;
    step(); step();
    checks++; if (cap.level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", cap.level); end
    checks++; if ({cap.out_valid, cap.busy, cap.done, cap.overflow} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {cap.out_valid, cap.busy, cap.done, cap.overflow}); end
    checks++; if (cap.out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", cap.out_data); end
    rst_n = 1'b1;
  endtask
  task automatic test_basic();
    cap.out_ready = 1'b1;
    cap.start = 1'b1; cap.len = 10'd5;
    step();
    cap.start = 1'b0; cap.len = 10'd9;
    checks++; if (cap.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", cap.busy); end
    run_stream(10, 8'h10, 1'b0);
    checks++; if (got.size() !== 5) begin errors++; $display("FAIL basic_count got %0d want 5", got.size()); end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      checks++; if (got[i] !== 8'h10 + 8'(i)) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", i, got[i], 8'h10 + 8'(i)); end
    end
    checks++; if (dones !== 1 || done_cycle !== 4) begin errors++; $display("FAIL basic_done got %0d pulses at %0d want 1 at 4", dones, done_cycle); end
    checks++; if (cap.overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow got %b want 0", cap.overflow); end
  endtask
  task automatic test_overflow();
    cap.out_ready = 1'b0;
    cap.start = 1'b1; cap.len = 10'd20;
    step();
    cap.start = 1'b0;
    run_stream(20, 8'h20, 1'b0);
    checks++; if (dones !== 1 || done_cycle !== 19) begin errors++; $display("FAIL ovf_done got %0d pulses at %0d want 1 at 19", dones, done_cycle); end
    checks++; if (cap.level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", cap.level); end
    checks++; if (cap.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", cap.overflow); end
    step(); step();
    checks++; if (cap.out_data !== 8'h20) begin errors++; $display("FAIL ovf_hold got %h want 20", cap.out_data); end
    cap.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (cap.out_valid !== 1'b1 || cap.out_data !== 8'h20 + 8'(i)) begin errors++; $display("FAIL ovf_drain[%0d] got %b/%h want 1/%h", i, cap.out_valid, cap.out_data, 8'h20 + 8'(i)); end
      step();
    end
    checks++; if (cap.level !== 5'd0 || cap.out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %0d/%b want 0/0", cap.level, cap.out_valid); end
    checks++; if (cap.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", cap.overflow); end
  endtask
  task automatic test_len0();
    cap.out_ready = 1'b1;
    cap.start = 1'b1; cap.len = 10'd0;
    step();
    cap.start = 1'b0;
    checks++; if (cap.done !== 1'b1 || cap.busy !== 1'b0) begin errors++; $display("FAIL len0_done got done=%b busy=%b want 1/0", cap.done, cap.busy); end
    cap.y_valid = 1'b1; cap.y = 8'h99;
    step();
    cap.y_valid = 1'b0;
    checks++; if (cap.done !== 1'b0 || cap.busy !== 1'b0) begin errors++; $display("FAIL len0_pulse got done=%b busy=%b want 0/0", cap.done, cap.busy); end
    checks++; if (cap.level !== 5'd0) begin errors++; $display("FAIL len0_level got %0d want 0", cap.level); end
  endtask
  task automatic test_full_push_pop();
    cap.out_ready = 1'b0;
    cap.start = 1'b1; cap.len = 10'd17;
    step();
    cap.start = 1'b0;
    run_stream(16, 8'h40, 1'b0);
    checks++; if (cap.level !== 5'd16 || cap.overflow !== 1'b0) begin errors++; $display("FAIL full_fill got %0d/%b want 16/0", cap.level, cap.overflow); end
    cap.y_valid = 1'b1; cap.y = 8'h50; cap.out_ready = 1'b1;
    checks++; if (cap.out_data !== 8'h40) begin errors++; $display("FAIL full_head got %h want 40", cap.out_data); end
    cap.out_ready = 1'b1;
    step();
    cap.y_valid = 1'b0; cap.out_ready = 1'b0;
    checks++; if (cap.level !== 5'd16 || cap.overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop got %0d/%b want 16/0", cap.level, cap.overflow); end
    checks++; if (cap.done !== 1'b1) begin errors++; $display("FAIL full_done got %b want 1", cap.done); end
    cap.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (cap.out_data !== ((i == 15) ? 8'h50 : 8'h41 + 8'(i))) begin errors++; $display("FAIL full_drain[%0d] got %h want %h", i, cap.out_data, (i == 15) ? 8'h50 : 8'h41 + 8'(i)); end
      step();
    end
    checks++; if (cap.level !== 5'd0) begin errors++; $display("FAIL full_empty got %0d want 0", cap.level); end
  endtask
  task automatic test_reset_mid();
    cap.out_ready = 1'b0;
    cap.start = 1'b1; cap.len = 10'd8;
    step();
    cap.start = 1'b0;
    run_stream(3, 8'h60, 1'b0);
    checks++; if (cap.level !== 5'd3 || cap.busy !== 1'b1) begin errors++; $display("FAIL mid_pre got %0d/%b want 3/1", cap.level, cap.busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (cap.level !== 5'd0 || {cap.out_valid, cap.busy, cap.done, cap.overflow} !== 4'b0 || cap.out_data !== 8'h00) begin errors++; $display("FAIL mid_async got level=%0d flags=%b data=%h want 0/0000/00", cap.level, {cap.out_valid, cap.busy, cap.done, cap.overflow}, cap.out_data); end
    cap.y_valid = 1'b1;
    step();
    cap.y_valid = 1'b0;
    checks++; if (cap.done !== 1'b0 || cap.busy !== 1'b0) begin errors++; $display("FAIL mid_held got done=%b busy=%b want 0/0", cap.done, cap.busy); end
    rst_n = 1'b1;
    cap.start = 1'b1; cap.len = 10'd2; cap.out_ready = 1'b1;
    step();
    cap.start = 1'b0;
    checks++; if (cap.busy !== 1'b1) begin errors++; $display("FAIL mid_restart got %b want 1", cap.busy); end
    run_stream(4, 8'h70, 1'b0);
    checks++; if (got.size() !== 2 || got[0] !== 8'h70 || got[1] !== 8'h71) begin errors++; $display("FAIL mid_data got %0d items want 70,71"  , got.size()); end
    checks++; if (dones !== 1 || done_cycle !== 1) begin errors++; $display("FAIL mid_done got %0d pulses at %0d want 1 at 1", dones, done_cycle); end
  endtask
  task automatic test_gaps();
    cap.out_ready = 1'b1;
    cap.start = 1'b1; cap.len = 10'd3;
    step();
    cap.start = 1'b0;
    run_stream(8, 8'h80, 1'b1);
    checks++; if (got.size() !== 3) begin errors++; $display("FAIL gap_count got %0d want 3", got.size()); end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      checks++; if (got[i] !== 8'h80 + 8'(2 * i)) begin errors++; $display("FAIL gap_data[%0d] got %h want %h", i, got[i], 8'h80 + 8'(2 * i)); end
    end
    checks++; if (dones !== 1 || done_cycle !== 4) begin errors++; $display("FAIL gap_done got %0d pulses at %0d want 1 at 4", dones, done_cycle); end
    checks++; if (busy_seen !== 4) begin errors++; $display("FAIL gap_busy got %0d cycles want 4", busy_seen); end
    checks++; if (cap.level !== 5'd0) begin errors++; $display("FAIL gap_level got %0d want 0", cap.level); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_len0();
    test_full_push_pop();
    test_reset_mid();
    test_gaps();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
